// File: rtl/elevator_ctrl.sv
// Collective-control (SCAN) elevator controller for one car.
// Latches calls, tracks position from shaft sensors, drives motor and doors.
module elevator_ctrl #(
  parameter int FLOORS      = 4,
  parameter int DOOR_CYCLES = 8,
  parameter int FW          = $clog2(FLOORS)
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [FLOORS-1:0] in_call,
  input  logic [FLOORS-1:0] out_call,
  input  logic [FLOORS-1:0] loc,
  output logic [1:0]        motor,
  output logic [FLOORS-1:0] door,
  output logic [FW-1:0]     cur_floor,
  output logic [FLOORS-1:0] pending,
  output logic              sensor_err
);

  localparam int TW = $clog2(DOOR_CYCLES + 1);
  localparam logic [TW-1:0] TLOAD = TW'(DOOR_CYCLES - 1);
  localparam logic [1:0] M_IDLE = 2'b00;
  localparam logic [1:0] M_UP   = 2'b10;
  localparam logic [1:0] M_DN   = 2'b11;

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DN,
    DOOR_OPEN
  } state_t;

  state_t            state;
  state_t            dec_st;
  logic              dir;
  logic              dec_dir;
  logic [TW-1:0]     timer;
  logic [FLOORS-1:0] cur_mask;
  logic [FLOORS-1:0] clr;
  logic [FW-1:0]     loc_idx;
  logic              loc_one;
  logic              loc_multi;
  logic              here;
  logic              above;
  logic              below;
  logic              call_here;
  logic              go;
  logic              moving;
  logic              stop_here;

  assign cur_mask  = {{(FLOORS-1){1'b0}}, 1'b1} << cur_floor;
  assign loc_one   = $onehot(loc);
  assign loc_multi = !$onehot0(loc);
  assign call_here = |((in_call | out_call) & cur_mask);
  assign moving    = (state == MOVE_UP) || (state == MOVE_DN);
  assign stop_here = loc_one && |(loc & pending);

  always_comb begin
    loc_idx = '0;
    for (int i = 0; i < FLOORS; i++) begin
      if (loc[i]) loc_idx = FW'(i);
    end
  end

  always_comb begin
    above = 1'b0;
    below = 1'b0;
    for (int i = 0; i < FLOORS; i++) begin
      if (FW'(i) > cur_floor) above = above | pending[i];
      if (FW'(i) < cur_floor) below = below | pending[i];
    end
  end

  // Door close ignores the current floor: its calls were masked while open.
  assign here = (state == IDLE) && |(pending & cur_mask);
  assign go = (state == IDLE) ||
              ((state == DOOR_OPEN) && !call_here && (timer == '0));

  always_comb begin
    dec_st  = IDLE;
    dec_dir = dir;
    if (here) begin
      dec_st = DOOR_OPEN;
    end else if (dir ? above : below) begin
      dec_st = dir ? MOVE_UP : MOVE_DN;
    end else if (dir ? below : above) begin
      dec_dir = !dir;
      dec_st  = dir ? MOVE_DN : MOVE_UP;
    end
  end

  always_comb begin
    clr = '0;
    if (state == DOOR_OPEN || (go && dec_st == DOOR_OPEN)) begin
      clr = cur_mask;
    end else if (moving && stop_here) begin
      clr = loc;
    end
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      dir        <= 1'b1;
      timer      <= '0;
      motor      <= M_IDLE;
      door       <= '0;
      cur_floor  <= '0;
      pending    <= '0;
      sensor_err <= 1'b0;
    end else begin
      pending <= (pending | in_call | out_call) & ~clr;
      if (loc_one) cur_floor <= loc_idx;
      if (loc_multi) sensor_err <= 1'b1;
      if (go) begin
        state <= dec_st;
        dir   <= dec_dir;
        motor <= M_IDLE;
        door  <= '0;
        unique case (dec_st)
          DOOR_OPEN: begin
            door  <= cur_mask;
            timer <= TLOAD;
          end
          MOVE_UP: motor <= M_UP;
          MOVE_DN: motor <= M_DN;
          default: ;
        endcase
      end else begin
        unique case (state)
          MOVE_UP, MOVE_DN: begin
            if (stop_here) begin
              state <= DOOR_OPEN;
              motor <= M_IDLE;
              door  <= loc;
              timer <= TLOAD;
            end else if ((state == MOVE_UP && loc[FLOORS-1]) ||
                         (state == MOVE_DN && loc[0])) begin
              state <= IDLE;
              motor <= M_IDLE;
            end
          end
          DOOR_OPEN: begin
            if (call_here) timer <= TLOAD;
            else           timer <= timer - TW'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_elevator_ctrl.sv
// Directed bench for elevator_ctrl, FLOORS=4, DOOR_CYCLES=3.
// Hand-computed expectations, checked one cycle after each rising edge.
module tb_elevator_ctrl;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic [3:0] in_call = '0;
  logic [3:0] out_call = '0;
  logic [3:0] loc = 4'b0001;
  logic [1:0] motor;
  logic [3:0] door;
  logic [1:0] cur_floor;
  logic [3:0] pending;
  logic       sensor_err;

  int nchk = 0;
  int nerr = 0;

  elevator_ctrl #(.FLOORS(4), .DOOR_CYCLES(3)) dut (
    .CLK(CLK),
    .RST(RST),
    .in_call(in_call),
    .out_call(out_call),
    .loc(loc),
    .motor(motor),
    .door(door),
    .cur_floor(cur_floor),
    .pending(pending),
    .sensor_err(sensor_err)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic st(input string tag, input logic [1:0] m,
                    input logic [3:0] d, input logic [3:0] p);
    chk({tag, ".motor"}, 32'(motor), 32'(m));
    chk({tag, ".door"}, 32'(door), 32'(d));
    chk({tag, ".pend"}, 32'(pending), 32'(p));
  endtask

  initial begin
    #3;
    st("rst", 2'b00, 4'b0000, 4'b0000);
    chk("rst.floor", 32'(cur_floor), 0);
    chk("rst.serr", 32'(sensor_err), 0);
    #4 RST = 1'b1;
    tick();

    // Basic trip 0 -> 2
    in_call = 4'b0100;
    tick();
    in_call = '0;
    st("t1.latch", 2'b00, 4'b0000, 4'b0100);
    tick();
    st("t1.go", 2'b10, 4'b0000, 4'b0100);
    loc = 4'b0000; tick();
    loc = 4'b0010; tick();
    st("t1.pass1", 2'b10, 4'b0000, 4'b0100);
    chk("t1.floor1", 32'(cur_floor), 1);
    loc = 4'b0000; tick();
    loc = 4'b0100; tick();
    st("t1.arrive", 2'b00, 4'b0100, 4'b0000);
    chk("t1.floor2", 32'(cur_floor), 2);
    tick();
    chk("t1.door2", 32'(door), 'b0100);
    tick();
    chk("t1.door3", 32'(door), 'b0100);
    tick();
    st("t1.close", 2'b00, 4'b0000, 4'b0000);

    // Door reload by a call at the open floor
    out_call = 4'b0100;
    tick();
    out_call = '0;
    chk("t3.latch", 32'(pending), 'b0100);
    tick();
    st("t3.open", 2'b00, 4'b0100, 4'b0000);
    tick();
    in_call = 4'b0100;
    tick();
    in_call = '0;
    st("t3.press", 2'b00, 4'b0100, 4'b0000);
    tick();
    chk("t3.hold1", 32'(door), 'b0100);
    tick();
    st("t3.hold2", 2'b00, 4'b0100, 4'b0000);
    tick();
    st("t3.close", 2'b00, 4'b0000, 4'b0000);

    // Up to 3 with a ground call, then reverse
    RST = 1'b0;
    loc = 4'b0010;
    #2 RST = 1'b1;
    tick();
    chk("t2.floor1", 32'(cur_floor), 1);
    in_call = 4'b1000;
    tick();
    in_call = '0;
    tick();
    st("t2.go", 2'b10, 4'b0000, 4'b1000);
    out_call = 4'b0001;
    tick();
    out_call = '0;
    st("t2.hall", 2'b10, 4'b0000, 4'b1001);
    loc = 4'b0000; tick();
    loc = 4'b0100; tick();
    chk("t2.pass2", 32'(motor), 'b10);
    loc = 4'b0000; tick();
    loc = 4'b1000; tick();
    st("t2.arr3", 2'b00, 4'b1000, 4'b0001);
    chk("t2.floor3", 32'(cur_floor), 3);
    tick();
    tick();
    chk("t2.door3", 32'(door), 'b1000);
    tick();
    st("t2.rev", 2'b11, 4'b0000, 4'b0001);
    loc = 4'b0100; tick();
    loc = 4'b0010; tick();
    chk("t2.pass1", 32'(motor), 'b11);
    loc = 4'b0001; tick();
    st("t2.arr0", 2'b00, 4'b0001, 4'b0000);
    tick(); tick(); tick();
    st("t2.idle", 2'b00, 4'b0000, 4'b0000);

    // Skipped target: top sensor without a call stops at end of shaft
    in_call = 4'b0100;
    tick();
    in_call = '0;
    tick();
    chk("t4.go", 32'(motor), 'b10);
    loc = 4'b0000; tick();
    loc = 4'b0010; tick();
    loc = 4'b0000; tick();
    loc = 4'b1000; tick();
    st("t4.top", 2'b00, 4'b0000, 4'b0100);
    chk("t4.floor3", 32'(cur_floor), 3);
    tick();
    chk("t4.down", 32'(motor), 'b11);
    loc = 4'b0100; tick();
    st("t4.arr2", 2'b00, 4'b0100, 4'b0000);
    tick(); tick(); tick();
    chk("t4.close", 32'(door), 0);

    // Multi-bit sensor sample
    loc = 4'b0110; tick();
    chk("t5.serr", 32'(sensor_err), 1);
    chk("t5.floor", 32'(cur_floor), 2);
    st("t5.quiet", 2'b00, 4'b0000, 4'b0000);
    loc = 4'b0100; tick();
    chk("t5.sticky", 32'(sensor_err), 1);
    loc = 4'b1001; tick();
    chk("t5.floor2", 32'(cur_floor), 2);
    loc = 4'b0100; tick();

    // Asynchronous reset while moving down
    in_call = 4'b0001;
    tick();
    in_call = '0;
    tick();
    chk("t6.go", 32'(motor), 'b11);
    loc = 4'b0000;
    in_call = 4'b1000;
    tick();
    in_call = '0;
    st("t6.run", 2'b11, 4'b0000, 4'b1001);
    #2 RST = 1'b0;
    #1;
    st("t6.async", 2'b00, 4'b0000, 4'b0000);
    chk("t6.floor", 32'(cur_floor), 0);
    chk("t6.serr", 32'(sensor_err), 0);
    loc = 4'b0001;
    #2 RST = 1'b1;
    tick();
    st("t6.idle", 2'b00, 4'b0000, 4'b0000);
    tick();
    chk("t6.still", 32'(motor), 0);
    chk("t6.floor0", 32'(cur_floor), 0);

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end

  always @(negedge CLK) begin
    if (RST && motor != 2'b00 && door != 4'b0000) begin
      nerr++;
      $display("FAIL excl: motor %b with door %b", motor, door);
    end
  end

  initial begin
    #50000;
    $display("FAIL timeout: bench did not complete");
    $fatal(1);
  end

endmodule

// File: doc/elevator_ctrl.md
# elevator_ctrl

Parametrised collective-control (SCAN) elevator controller for a single car serving `FLOORS` landings. It latches in-car and hall calls into a pending register and drives the hoist motor code and per-floor door enables. Car position comes from one-hot shaft sensors. It sits between the call-button debouncers and the motor/door driver stage, and replaces the fixed three-floor movement controller.

## Interface
- `FLOORS`, default 4: number of landings, ≥2; floor 0 is the ground floor.
- `DOOR_CYCLES`, default 8: number of cycles the door stays open per stop, ≥1.
- `FW`, default `$clog2(FLOORS)`: width of `cur_floor`.
- `CLK`, input, 1: clock, rising edge.
- `RST`, input, 1: reset, asynchronous, active-low.
- `in_call`, input, FLOORS: in-car buttons, level, one bit per floor.
- `out_call`, input, FLOORS: hall buttons, level, one bit per floor.
- `loc`, input, FLOORS: one-hot shaft sensors; all-zero means the car is between floors.
- `motor`, output, 2: motor command; 00 idle, 10 up, 11 down.
- `door`, output, FLOORS: one-hot door-open enable; all-zero means doors closed.
- `cur_floor`, output, FW: last valid floor seen on `loc`.
- `pending`, output, FLOORS: latched unserved calls.
- `sensor_err`, output, 1: sticky flag; set when `loc` has more than one bit set.

## Operation
- FSM states: IDLE, MOVE_UP, MOVE_DN, DOOR_OPEN. Direction register `dir`: 1 = up, 0 = down.
- Call latching, every edge: `pending <= (pending | in_call | out_call) & ~clr`. `clr` is the one-hot mask of the floor being served on this edge. Clear wins over a new call on the same floor in the same cycle.
- Position: when `loc` is exactly one-hot, `cur_floor <=` its index. When `loc` is all-zero, `cur_floor` holds. When `loc` has more than one bit set, the sample is ignored and `sensor_err <= 1`; only reset clears it.
- Request classes, computed from `pending` relative to `cur_floor`:
  - `here`: the pending bit at `cur_floor`.
  - `above`: any pending bit at a floor higher than `cur_floor`.
  - `below`: any pending bit at a floor lower than `cur_floor`.
- Decision function, used in IDLE and at door close:
  - Priority 1: `here` → DOOR_OPEN.
  - Priority 2: request ahead in `dir` → move in `dir`.
  - Priority 3: request in the opposite direction → flip `dir` and move that way.
  - Otherwise → IDLE.
- IDLE: evaluates the decision function every cycle.
- MOVE_UP / MOVE_DN: `motor` = 10 / 11. When a valid one-hot `loc` reports floor f:
  - If `pending[f]` is set → DOOR_OPEN at f.
  - Else if f = FLOORS-1 in MOVE_UP, or f = 0 in MOVE_DN → IDLE (end-of-shaft stop).
  - Else keep moving.
- DOOR_OPEN:
  - On entry: `motor` = 00, `door[cur_floor]` = 1, `pending[cur_floor]` cleared, timer loaded with DOOR_CYCLES-1.
  - Each cycle the timer decrements. A call at `cur_floor` while the door is open reloads the timer to DOOR_CYCLES-1 and is not latched.
  - When the timer is 0, the next edge applies the decision function with `here` forced to 0.
- `door` and `motor` are never both nonzero in the same cycle.

## Timing
- All outputs are registered.
- Reset values: `motor` = 00, `door` = 0, `cur_floor` = 0, `pending` = 0, `sensor_err` = 0, state IDLE, `dir` = 1, timer 0.
- Call to `pending` bit: 1 cycle.
- IDLE with `pending` nonzero → `motor` or `door` asserted on the next edge (1 cycle).
- Arrival (`loc[f]` sampled with `pending[f]` set) → on the same next edge: `motor` = 00, `door[f]` = 1, `pending[f]` = 0.
- `door` stays high exactly DOOR_CYCLES cycles, plus any reloads. On the edge it drops, `motor` takes its new value directly, with no idle gap cycle.
- Reset asserted mid-motion or with the door open: all outputs go to their reset values immediately (asynchronous). Pending calls are lost.

## Test plan
- FLOORS=4, DOOR_CYCLES=3; after reset, pulse `in_call[2]` for 1 cycle → `pending` = 0100 next cycle, then `motor` = 10. After `loc` steps 0001→0000→0010→0000→0100, the next edge gives `motor` = 00, `door` = 0100, `cur_floor` = 2, `pending` = 0. `door` stays high 3 cycles, then the controller returns to IDLE.
- Car at floor 1 moving up to call 3; `out_call[0]` raised meanwhile → car stops at 3 (door 1000). At door close `dir` flips and `motor` = 11; it then stops at 0.
- Car at floor 2 with the door open; `in_call[2]` held on the second door cycle → `door` stays high 3 cycles after the press and `pending[2]` remains 0.
- Moving up with `pending` = 0000 (call served externally impossible, forced via stimulus) and `loc` = 1000 → IDLE, `motor` = 00, no door.
- `loc` = 0110 for 1 cycle → `sensor_err` = 1, `cur_floor` unchanged. `sensor_err` stays 1 until `RST` is low.
- `RST` pulled low while `motor` = 11 and between edges → `motor` = 00, `pending` = 0 immediately; after release the controller is idle at floor 0.
